// File: rtl/alu_md_control.sv
// ALU operation decode plus iterative RV32M multiply/divide engine with stall.
// Optional: define ALU_MD_EARLY_OUT_EN to skip BUSY on trivial M-ops.
module alu_md_control #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [3:0]      Operation,
  output logic            stall_o,
  output logic            md_done_o,
  output logic [XLEN-1:0] md_result_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        f3_q, f3_d;
  logic              a_neg_q, a_neg_d;
  logic              b_neg_q, b_neg_d;
  logic              div0_q, div0_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   res_q, res_d;

  always_comb begin
    Operation = 4'b0010;
    case (ALUOp)
      2'b00: if (funct3 == 3'b001) Operation = 4'b0011;
      2'b01: begin
        case (funct3)
          3'b100:  Operation = 4'b1000;
          3'b101:  Operation = 4'b1010;
          default: Operation = 4'b0101;
        endcase
      end
      2'b10: begin
        unique case (1'b1)
          funct7 == 7'b0000001:
            Operation = 4'b1111;
          funct7 == 7'b0100000 && funct3 == 3'b000:
            Operation = 4'b0110;
          funct7 == 7'b0000000: begin
            case (funct3)
              3'b111:  Operation = 4'b0000;
              3'b110:  Operation = 4'b0001;
              3'b100:  Operation = 4'b0100;
              default: Operation = 4'b0010;
            endcase
          end
          default: Operation = 4'b0010;
        endcase
      end
      default: Operation = 4'b1110;
    endcase
  end

  logic            md_start;
  logic            a_sg, b_sg, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  // rs1 is unsigned for MULHU, DIVU, REMU; rs2 additionally for MULHSU
  assign a_sg  = ~(funct3[0] & (funct3[1] | funct3[2]));
  assign b_sg  = a_sg & (funct3 != 3'b010);
  assign a_neg = a_sg & rs1_i[XLEN-1];
  assign b_neg = b_sg & rs2_i[XLEN-1];
  assign a_mag = a_neg ? -rs1_i : rs1_i;
  assign b_mag = b_neg ? -rs2_i : rs2_i;

  assign md_start = valid_i & (Operation == 4'b1111)
                  & (state_q == IDLE) & ~flush_i;

`ifdef ALU_MD_EARLY_OUT_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  logic            zdiv, ovf, early;
  logic [XLEN-1:0] early_res;

  always_comb begin
    zdiv = (rs2_i == '0);
    ovf  = a_sg & (rs1_i == MIN_NEG) & (&rs2_i);
    early = funct3[2] ? (zdiv | ovf) : ((rs1_i == '0) | zdiv);
    early_res = '0;
    if (funct3[2] & zdiv) early_res = funct3[1] ? rs1_i : '1;
    else if (funct3[2] & ovf) early_res = funct3[1] ? '0 : MIN_NEG;
  end
`endif

  logic [XLEN:0]     add_sum, sub_shift, sub_diff;
  logic [2*XLEN-1:0] step_acc, prod;
  logic [XLEN-1:0]   quo, rem, q_fix, r_fix, fin_res;

  // acc holds {hi, lo}: product halves for mul, {remainder, quotient} for div
  always_comb begin
    add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
              + (acc_q[0] ? {1'b0, opb_q} : '0);
    sub_shift = acc_q[2*XLEN-1:XLEN-1];
    sub_diff  = sub_shift - {1'b0, opb_q};
    if (!f3_q[2])
      step_acc = {add_sum, acc_q[XLEN-1:1]};
    else if (sub_diff[XLEN])
      step_acc = {sub_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else
      step_acc = {sub_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    prod  = (a_neg_q ^ b_neg_q) ? -step_acc : step_acc;
    quo   = step_acc[XLEN-1:0];
    rem   = step_acc[2*XLEN-1:XLEN];
    q_fix = ((a_neg_q ^ b_neg_q) && !div0_q) ? -quo : quo;
    r_fix = a_neg_q ? -rem : rem;

    case (f3_q)
      3'b000:                fin_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        fin_res = q_fix;
      default:               fin_res = r_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    f3_d    = f3_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    div0_d  = div0_q;
    done_d  = 1'b0;
    res_d   = res_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_start) begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
            acc_d   = {{XLEN{1'b0}}, a_mag};
            opb_d   = b_mag;
            f3_d    = funct3;
            a_neg_d = a_neg;
            b_neg_d = b_neg;
            div0_d  = (rs2_i == '0);
`ifdef ALU_MD_EARLY_OUT_EN
            if (early) begin
              state_d = DONE;
              cnt_d   = '0;
              done_d  = 1'b1;
              res_d   = early_res;
            end
`endif
          end
        end
        BUSY: begin
          acc_d = step_acc;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            res_d   = fin_res;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      f3_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      f3_q    <= f3_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign stall_o     = md_start | (state_q == BUSY);
  assign md_done_o   = done_q;
  assign md_result_o = res_q;

endmodule

// File: tb/tb_alu_md_control.sv
// Randomised self-checking bench for alu_md_control (XLEN=32).
// Reference model uses plain 64-bit arithmetic; honours ALU_MD_EARLY_OUT_EN.
module tb_alu_md_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        flush_i;
  logic [1:0]  ALUOp;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [3:0]  Operation;
  logic        stall_o;
  logic        md_done_o;
  logic [31:0] md_result_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] last_exp;

`ifdef ALU_MD_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  alu_md_control #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .flush_i(flush_i),
    .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .Operation(Operation),
    .stall_o(stall_o), .md_done_o(md_done_o), .md_result_o(md_result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] model_op(logic [1:0] op, logic [2:0] f3,
                                          logic [6:0] f7);
    if (op == 2'd0) return (f3 == 3'd1) ? 4'd3 : 4'd2;
    if (op == 2'd1) return (f3 == 3'd4) ? 4'd8 : (f3 == 3'd5) ? 4'd10 : 4'd5;
    if (op == 2'd3) return 4'd14;
    if (f7 == 7'h01) return 4'd15;
    if (f7 == 7'h20 && f3 == 3'd0) return 4'd6;
    if (f7 == 7'h00) begin
      if (f3 == 3'd7) return 4'd0;
      if (f3 == 3'd6) return 4'd1;
      if (f3 == 3'd4) return 4'd4;
    end
    return 4'd2;
  endfunction

  function automatic logic [31:0] model_md(logic [2:0] f3, logic [31:0] a,
                                           logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(logic [2:0] f3, logic [31:0] a,
                                   logic [31:0] b);
    logic e;
    if (f3[2])
      e = (b == 0) || ((f3 == 3'd4 || f3 == 3'd6) &&
          a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else
      e = (a == 0) || (b == 0);
    return (EARLY && e) ? 1 : 33;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Presents one M-op and observes it until md_done_o (bounded).
  task automatic run_mop(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit drop,
                         output logic [31:0] res, output int lat,
                         output int stalls, output int t0, output int td);
    @(negedge clk);
    valid_i = 1'b1; ALUOp = 2'b10; funct7 = 7'h01;
    funct3 = f3; rs1_i = a; rs2_i = b;
    #1;
    if (!stall_o) begin @(posedge clk); #1; end
    t0 = cyc;
    stalls = stall_o ? 1 : 0;
    lat = -1;
    res = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (stall_o) stalls++;
      if (md_done_o) begin lat = c; res = md_result_o; break; end
    end
    td = cyc;
    if (drop) begin @(negedge clk); valid_i = 1'b0; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
    ALUOp = 2'b00; funct3 = 3'd0; funct7 = 7'd0; rs1_i = 0; rs2_i = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL reset_stall got=%b want=0", stall_o);
    end
    total++;
    if (md_done_o !== 1'b0) begin
      bad++; $display("FAIL reset_done got=%b want=0", md_done_o);
    end
    total++;
    if (md_result_o !== 32'h0) begin
      bad++; $display("FAIL reset_result got=%h want=0", md_result_o);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [6:0] f7s[4];
    logic [3:0] exp_op;
    valid_i = 1'b0;
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01;
    f7s[3] = 7'($urandom_range(0, 127));
    for (int op = 0; op < 4; op++)
      for (int f3 = 0; f3 < 8; f3++)
        for (int k = 0; k < 4; k++) begin
          ALUOp = 2'(op); funct3 = 3'(f3); funct7 = f7s[k];
          #1;
          exp_op = model_op(ALUOp, funct3, funct7);
          total++;
          if (Operation !== exp_op) begin
            bad++;
            $display("FAIL decode op=%0d f3=%0d f7=%h got=%h want=%h",
                     op, f3, funct7, Operation, exp_op);
          end
        end
  endtask

  task automatic check_mop(input string name, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] want);
    logic [31:0] res;
    int lat, st, t0, td, wl;
    run_mop(f3, a, b, 1'b1, res, lat, st, t0, td);
    wl = model_lat(f3, a, b);
    total++;
    if (res !== want) begin
      bad++; $display("FAIL %s result got=%h want=%h", name, res, want);
    end
    total++;
    if (lat != wl) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, wl);
    end
    total++;
    if (st != wl) begin
      bad++; $display("FAIL %s stall_cycles got=%0d want=%0d", name, st, wl);
    end
    last_exp = want;
  endtask

  task automatic test_mul_fixed();
    check_mop("mul_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    check_mop("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    check_mop("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
  endtask

  task automatic test_div_fixed();
    check_mop("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    check_mop("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    check_mop("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    check_mop("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    check_mop("divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
    check_mop("remu_z", 3'd7, 32'd5, 32'd0, 32'd5);
    check_mop("div_neg_z", 3'd4, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF);
    check_mop("rem_neg_z", 3'd6, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0);
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = rnd_val();
      b = rnd_val();
      check_mop($sformatf("rand%0d_f3=%0d_a=%h_b=%h", i, f3, a, b),
                f3, a, b, model_md(f3, a, b));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int l1, l2, s1, s2, t01, t02, td1, td2;
    run_mop(3'd0, 32'd1234, 32'd5678, 1'b0, r1, l1, s1, t01, td1);
    run_mop(3'd5, 32'd1000, 32'd7, 1'b1, r2, l2, s2, t02, td2);
    total++;
    if (r1 !== 32'd7006652) begin
      bad++; $display("FAIL b2b_first got=%h want=%h", r1, 32'd7006652);
    end
    total++;
    if (r2 !== 32'd142) begin
      bad++; $display("FAIL b2b_second got=%h want=%h", r2, 32'd142);
    end
    total++;
    if (t02 != td1 + 1) begin
      bad++; $display("FAIL b2b_accept_gap got=%0d want=1", t02 - td1);
    end
    last_exp = 32'd142;
  endtask

  task automatic test_flush();
    bit seen;
    check_mop("pre_flush", 3'd5, 32'd100, 32'd7, 32'd14);
    @(negedge clk);
    valid_i = 1'b1; ALUOp = 2'b10; funct7 = 7'h01;
    funct3 = 3'd0; rs1_i = 32'd77; rs2_i = 32'd91;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL flush_stall got=%b want=0", stall_o);
    end
    total++;
    if (md_result_o !== last_exp) begin
      bad++; $display("FAIL flush_result got=%h want=%h", md_result_o, last_exp);
    end
    @(negedge clk); flush_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (md_done_o) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL flush_no_done got=1 want=0");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    valid_i = 1'b1; ALUOp = 2'b10; funct7 = 7'h01;
    funct3 = 3'd0; rs1_i = 32'd7; rs2_i = 32'd9;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; valid_i = 1'b0;
    @(posedge clk); #1;
    total++;
    if (stall_o !== 1'b0) begin
      bad++; $display("FAIL midrst_stall got=%b want=0", stall_o);
    end
    total++;
    if (md_result_o !== 32'h0) begin
      bad++; $display("FAIL midrst_result got=%h want=0", md_result_o);
    end
    @(negedge clk); rst_n = 1'b1;
    check_mop("post_rst_mul", 3'd0, 32'd3, 32'd4, 32'd12);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_mul_fixed();
    test_div_fixed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
